// File: rtl/smc_pkg.sv
// Shared SMC definitions: instruction field positions, store-burst FSM
// states and beat byte-mask helpers.
package smc_pkg;

  // Instruction bus field positions (common to the load- and store-burst blocks).
  // The ur_id field [36:29] is carried on the bus but not consumed by stb.
  localparam int INS_VLD_BIT       = 127;
  localparam int INS_SMC_STRB_LO   = 121;
  localparam int INS_BYTE_STRB_HI  = 120;
  localparam int INS_BYTE_STRB_LO  = 117;
  localparam int INS_BURST_HI      = 116;
  localparam int INS_BURST_LO      = 101;
  localparam int INS_GR_HI         = 100;
  localparam int INS_GR_LO         = 37;
  localparam int INS_UR_ADDR_HI    = 28;
  localparam int INS_UR_ADDR_LO    = 18;

  localparam int BYTE_PER_BEAT     = 16;
  localparam int MAX_BEATS         = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PARSE = 3'd1,
    ST_REQ   = 3'd2,
    ST_DATA  = 3'd3,
    ST_RESP  = 3'd4,
    ST_DONE  = 3'd5
  } stb_state_t;

  // Byte strobes of the final beat: 0 means a full beat, n keeps the low n bytes.
  function automatic logic [15:0] last_beat_mask(input logic [3:0] byte_strb);
    logic [15:0] m;
    if (byte_strb == 4'd0) m = 16'hFFFF;
    else                   m = (16'h1 << byte_strb) - 16'h1;
    return m;
  endfunction

  // Widen a byte strobe into a bit mask over the 128-bit beat.
  function automatic logic [127:0] expand_strb(input logic [15:0] strb);
    logic [127:0] m;
    for (int b = 0; b < BYTE_PER_BEAT; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

endpackage

// File: rtl/stb_skid_buf.sv
// Two-entry FIFO holding write beats {data, strb, last} between the UR read
// port and the AXI write-data channel. The caller never pushes when full
// nor pops when empty.
module stb_skid_buf #(
  parameter int W = 145
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // Next-state of storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) mem_d[wr_ptr_q] = push_data;
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/stb.sv
// Store-burst engine: reads consecutive UR entries and writes them to global
// memory as one AXI write burst, reporting success/error on crd_stb_o.
//
// Handshakes: a transfer on the wreq and wdata channels happens in a cycle
// where valid && ready are both high; valid, and everything it qualifies,
// holds stable until that cycle and never depends on ready.
module stb
  import smc_pkg::*;
#(
  parameter int param_ur_byte_cnt = 16,
  parameter int ur_addr_w         = 11,
  parameter int gr_addr_w         = 64,
  parameter int brst_w            = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [127:0]                   cru_stb_i,
  output logic [127:0]                   cru_stb_o,
  output logic [1:0]                     crd_stb_o,
  output logic                           ur_re,
  output logic [ur_addr_w-1:0]           ur_raddr,
  input  logic [param_ur_byte_cnt*8-1:0] ur_rdata,
  output logic                           axi_wreq_valid,
  input  logic                           axi_wreq_ready,
  output logic [gr_addr_w-1:0]           axi_wreq_addr,
  output logic [8:0]                     axi_wreq_len,
  output logic                           axi_wdata_valid,
  input  logic                           axi_wdata_ready,
  output logic [127:0]                   axi_wdata,
  output logic [15:0]                    axi_wstrb,
  output logic                           axi_wdata_last,
  input  logic                           axi_wresp_done,
  input  logic                           axi_wresp_err,
  output stb_state_t                     dbg_state
);

  localparam int BUF_W = 128 + BYTE_PER_BEAT + 1;

  stb_state_t             state_q, state_d;
  logic [brst_w-1:0]      beats_q, beats_d;
  logic [brst_w-1:0]      rd_cnt_q, rd_cnt_d;
  logic [ur_addr_w-1:0]   rd_addr_q, rd_addr_d;
  logic [15:0]            mask_q, mask_d;
  logic                   inflight_q, inflight_d;
  logic                   inflight_last_q, inflight_last_d;
  logic                   done_seen_q, done_seen_d;
  logic                   err_q, err_d;
  logic [1:0]             crd_q, crd_d;
  logic                   wreq_valid_q, wreq_valid_d;
  logic [gr_addr_w-1:0]   wreq_addr_q, wreq_addr_d;
  logic [8:0]             wreq_len_q, wreq_len_d;

  // Instruction decode.
  logic [brst_w-1:0]    f_burst, beats_dec;
  logic [63:0]          f_gr;
  logic [ur_addr_w-1:0] f_ur_addr;
  logic [3:0]           f_byte_strb;
  logic [gr_addr_w-1:0] addr_dec;

  assign f_burst     = cru_stb_i[INS_BURST_HI:INS_BURST_LO];
  assign f_gr        = cru_stb_i[INS_GR_HI:INS_GR_LO];
  assign f_ur_addr   = cru_stb_i[INS_UR_ADDR_HI:INS_UR_ADDR_LO];
  assign f_byte_strb = cru_stb_i[INS_BYTE_STRB_HI:INS_BYTE_STRB_LO];
  assign beats_dec   = (f_burst == '0) ? brst_w'(1) : f_burst;
  assign addr_dec    = gr_addr_w'({f_gr, 4'b0000});

  // Skid buffer and read throttle.
  logic [BUF_W-1:0] push_word, head_word;
  logic             head_valid, wdata_fire, rd_last;
  logic [1:0]       buf_count;
  logic [2:0]       occ_after;
  logic [15:0]      push_strb;

  stb_skid_buf #(.W(BUF_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q),
    .push_data  (push_word),
    .pop        (wdata_fire),
    .head_data  (head_word),
    .head_valid (head_valid),
    .count      (buf_count)
  );

  assign axi_wdata_valid = head_valid && (state_q == ST_DATA);
  assign wdata_fire      = axi_wdata_valid && axi_wdata_ready;
  assign axi_wdata       = axi_wdata_valid ? head_word[BUF_W-1:17] : '0;
  assign axi_wstrb       = axi_wdata_valid ? head_word[16:1] : '0;
  assign axi_wdata_last  = axi_wdata_valid && head_word[0];

  // Occupancy the buffer will have once this cycle's pop and in-flight read
  // land; a new read is only allowed when that leaves room for it.
  assign occ_after = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, wdata_fire};
  assign ur_re     = ((state_q == ST_REQ) || (state_q == ST_DATA)) &&
                     (rd_cnt_q != beats_q) && (occ_after < 3'd2);
  assign ur_raddr  = rd_addr_q;
  assign rd_last   = (rd_cnt_q == beats_q - brst_w'(1));

  assign push_strb = inflight_last_q ? mask_q : 16'hFFFF;
  assign push_word = {ur_rdata & expand_strb(push_strb), push_strb, inflight_last_q};

  assign cru_stb_o      = cru_stb_i;
  assign crd_stb_o      = crd_q;
  assign axi_wreq_valid = wreq_valid_q;
  assign axi_wreq_addr  = wreq_addr_q;
  assign axi_wreq_len   = wreq_len_q;
  assign dbg_state      = state_q;

  // FSM next-state, read sequencing, early-response capture and registered outputs.
  always_comb begin
    state_d         = state_q;
    beats_d         = beats_q;
    rd_cnt_d        = rd_cnt_q;
    rd_addr_d       = rd_addr_q;
    mask_d          = mask_q;
    inflight_d      = ur_re;
    inflight_last_d = ur_re && rd_last;
    done_seen_d     = done_seen_q;
    err_d           = err_q;
    wreq_addr_d     = wreq_addr_q;
    wreq_len_d      = wreq_len_q;

    if (ur_re) begin
      rd_cnt_d  = rd_cnt_q + brst_w'(1);
      rd_addr_d = rd_addr_q + ur_addr_w'(1);
    end

    // A response can overtake the last beat; remember it for RESP.
    if (((state_q == ST_REQ) || (state_q == ST_DATA)) && axi_wresp_done) begin
      done_seen_d = 1'b1;
      err_d       = axi_wresp_err;
    end

    case (state_q)
      ST_IDLE: if (cru_stb_i[INS_VLD_BIT]) state_d = ST_PARSE;
      ST_PARSE: begin
        beats_d     = beats_dec;
        rd_cnt_d    = '0;
        rd_addr_d   = f_ur_addr;
        mask_d      = last_beat_mask(f_byte_strb);
        done_seen_d = 1'b0;
        err_d       = 1'b0;
        wreq_addr_d = addr_dec;
        wreq_len_d  = beats_dec[8:0];
        if (!cru_stb_i[INS_SMC_STRB_LO]) begin
          state_d = ST_DONE;
        end else if (beats_dec > brst_w'(MAX_BEATS)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ:  if (axi_wreq_ready) state_d = ST_DATA;
      ST_DATA: if (wdata_fire && head_word[0]) state_d = ST_RESP;
      ST_RESP: begin
        if (done_seen_q) begin
          state_d = ST_DONE;
        end else if (axi_wresp_done) begin
          state_d = ST_DONE;
          err_d   = axi_wresp_err;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    wreq_valid_d = (state_d == ST_REQ);
    crd_d        = (state_d == ST_DONE) ? {1'b1, ~err_d} : 2'b00;
  end

  // State and registered outputs; reset aborts any operation silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      beats_q         <= '0;
      rd_cnt_q        <= '0;
      rd_addr_q       <= '0;
      mask_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_seen_q     <= 1'b0;
      err_q           <= 1'b0;
      crd_q           <= 2'b00;
      wreq_valid_q    <= 1'b0;
      wreq_addr_q     <= '0;
      wreq_len_q      <= '0;
    end else begin
      state_q         <= state_d;
      beats_q         <= beats_d;
      rd_cnt_q        <= rd_cnt_d;
      rd_addr_q       <= rd_addr_d;
      mask_q          <= mask_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_seen_q     <= done_seen_d;
      err_q           <= err_d;
      crd_q           <= crd_d;
      wreq_valid_q    <= wreq_valid_d;
      wreq_addr_q     <= wreq_addr_d;
      wreq_len_q      <= wreq_len_d;
    end
  end

endmodule

// File: tb/tb_stb.sv
// Bench for the store-burst engine: UR memory model, AXI slave drivers,
// beat scoreboard and directed plus randomized instructions.
module tb_stb;
  import smc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] cru_stb_i = '0;
  logic [127:0] cru_stb_o;
  logic [1:0]   crd_stb_o;
  logic         ur_re;
  logic [10:0]  ur_raddr;
  logic [127:0] ur_rdata = '0;
  logic         axi_wreq_valid;
  logic         axi_wreq_ready = 1'b0;
  logic [63:0]  axi_wreq_addr;
  logic [8:0]   axi_wreq_len;
  logic         axi_wdata_valid;
  logic         axi_wdata_ready = 1'b0;
  logic [127:0] axi_wdata;
  logic [15:0]  axi_wstrb;
  logic         axi_wdata_last;
  logic         axi_wresp_done = 1'b0;
  logic         axi_wresp_err = 1'b0;
  stb_state_t   dbg_state;

  stb dut (
    .clk(clk), .rst(rst),
    .cru_stb_i(cru_stb_i), .cru_stb_o(cru_stb_o), .crd_stb_o(crd_stb_o),
    .ur_re(ur_re), .ur_raddr(ur_raddr), .ur_rdata(ur_rdata),
    .axi_wreq_valid(axi_wreq_valid), .axi_wreq_ready(axi_wreq_ready),
    .axi_wreq_addr(axi_wreq_addr), .axi_wreq_len(axi_wreq_len),
    .axi_wdata_valid(axi_wdata_valid), .axi_wdata_ready(axi_wdata_ready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wdata_last(axi_wdata_last),
    .axi_wresp_done(axi_wresp_done), .axi_wresp_err(axi_wresp_err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [127:0] ur_mem [2048];
  logic [127:0] exp_q [$];
  logic [15:0]  exp_strb_q [$];
  logic         exp_last_q [$];
  logic [10:0]  exp_raddr_q [$];
  logic [63:0]  exp_addr;
  logic [8:0]   exp_len;
  logic [1:0]   exp_crd;
  logic         exp_active;
  int           exp_beats;

  int cyc = 0;
  int n_re, n_fire, n_wreq_cyc, n_wreq_acc;
  int acc_cyc, first_valid_cyc, first_fire_cyc, last_fire_cyc;
  int rmode = 0;
  int wreq_mode = 0;
  int resp_cd = 0;
  int resp_delay = 0;
  logic resp_err = 1'b0;
  logic resp_early = 1'b0;
  logic stall_prev = 1'b0;
  logic [127:0] prev_data;
  logic [15:0]  prev_strb;
  logic         prev_last;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- UR memory: data exactly one cycle after ur_re ----------------
  initial begin
    logic        r;
    logic [10:0] a;
    forever begin
      @(negedge clk);
      r = ur_re;
      a = ur_raddr;
      @(posedge clk); #1;
      ur_rdata = r ? ur_mem[a] : rand128();
    end
  end

  // ---------------- AXI ready drivers ----------------
  initial begin
    int t;
    t = 0;
    forever begin
      @(posedge clk); #1;
      t++;
      case (rmode)
        0:       axi_wdata_ready = 1'b1;
        1:       axi_wdata_ready = ((t % 4) == 0) || ((t % 4) == 3);
        default: axi_wdata_ready = 1'($urandom_range(0, 1));
      endcase
      axi_wreq_ready = (wreq_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- AXI write response driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (resp_cd == 1) begin
        axi_wresp_done = 1'b1;
        axi_wresp_err  = resp_err;
        resp_cd = 0;
      end else begin
        axi_wresp_done = 1'b0;
        axi_wresp_err  = 1'($urandom_range(0, 1));
        if (resp_cd > 1) resp_cd--;
      end
    end
  end

  // ---------------- monitor: reads, request, beats ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (ur_re) begin
        check("ur_outstanding_le2", 128'((n_re - n_fire) <= 2), 128'd1);
        if (exp_raddr_q.size() == 0) check("ur_re_unexpected", 128'(ur_re), 128'd0);
        else check("ur_raddr", 128'(ur_raddr), 128'(exp_raddr_q.pop_front()));
        n_re++;
      end
      if (axi_wreq_valid) begin
        n_wreq_cyc++;
        if (axi_wreq_ready) begin
          check("wreq_addr", 128'(axi_wreq_addr), 128'(exp_addr));
          check("wreq_len", 128'(axi_wreq_len), 128'(exp_len));
          n_wreq_acc++;
          acc_cyc = cyc;
        end
      end
      if (axi_wdata_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stall_prev) begin
          check("stall_data", axi_wdata, prev_data);
          check("stall_strb", 128'(axi_wstrb), 128'(prev_strb));
          check("stall_last", 128'(axi_wdata_last), 128'(prev_last));
        end
        if (axi_wdata_ready) begin
          if (exp_q.size() == 0) check("beat_unexpected", 128'(axi_wdata_valid), 128'd0);
          else begin
            check("beat_data", axi_wdata, exp_q.pop_front());
            check("beat_strb", 128'(axi_wstrb), 128'(exp_strb_q.pop_front()));
            check("beat_last", 128'(axi_wdata_last), 128'(exp_last_q.pop_front()));
          end
          if (first_fire_cyc < 0) first_fire_cyc = cyc;
          last_fire_cyc = cyc;
          if ((resp_early && n_fire == 0) || (!resp_early && axi_wdata_last))
            resp_cd = resp_delay + 1;
          n_fire++;
        end
      end
      stall_prev = axi_wdata_valid && !axi_wdata_ready;
      prev_data  = axi_wdata;
      prev_strb  = axi_wstrb;
      prev_last  = axi_wdata_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_expect();
    exp_q.delete();
    exp_strb_q.delete();
    exp_last_q.delete();
    exp_raddr_q.delete();
  endtask

  task automatic launch(input logic [5:0] smc, input logic [3:0] bs, input logic [15:0] burst,
                        input logic [63:0] gr, input logic [10:0] ua, input int rm,
                        input logic err, input logic early, input int delay);
    int          beats;
    logic [10:0] a;
    logic [127:0] d;
    logic [15:0] s;
    clear_expect();
    n_re = 0; n_fire = 0; n_wreq_cyc = 0; n_wreq_acc = 0;
    acc_cyc = -1; first_valid_cyc = -1; first_fire_cyc = -1; last_fire_cyc = -1;
    resp_err = err; resp_early = early; resp_delay = delay; rmode = rm;
    beats      = (burst == 16'd0) ? 1 : int'(burst);
    exp_active = smc[0] && (beats <= 256);
    exp_beats  = exp_active ? beats : 0;
    exp_addr   = {gr[59:0], 4'b0000};
    exp_len    = 9'(beats);
    if (!smc[0])          exp_crd = 2'b11;
    else if (beats > 256) exp_crd = 2'b10;
    else                  exp_crd = err ? 2'b10 : 2'b11;
    if (exp_active) begin
      for (int i = 0; i < beats; i++) begin
        a = 11'((int'(ua) + i) % 2048);
        exp_raddr_q.push_back(a);
        d = ur_mem[a];
        s = 16'hFFFF;
        if (i == beats - 1 && bs != 4'd0) begin
          for (int b = 0; b < 16; b++) begin
            if (b >= int'(bs)) begin
              s[b] = 1'b0;
              d[b*8 +: 8] = 8'h00;
            end
          end
        end
        exp_q.push_back(d);
        exp_strb_q.push_back(s);
        exp_last_q.push_back(i == beats - 1);
      end
    end
    @(posedge clk); #1;
    cru_stb_i = {1'b1, smc, bs, burst, gr, 8'($urandom()), ua, 18'($urandom())};
    repeat (2) begin @(posedge clk); #1; end
    if (exp_active) begin
      // A second instruction while busy must be ignored.
      cru_stb_i = {1'b1, 127'(rand128())};
      #1 check("cru_passthrough", cru_stb_o, cru_stb_i);
      @(posedge clk); #1;
    end
    cru_stb_i = {1'b0, 127'(rand128())};
  endtask

  task automatic finish_instr();
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (crd_stb_o[1]) break;
    end
    check("crd_response", 128'(crd_stb_o), 128'(exp_crd));
    @(negedge clk);
    check("crd_pulse_width", 128'(crd_stb_o), 128'd0);
    check("back_to_idle", 128'(dbg_state), 128'(ST_IDLE));
    check("ur_read_count", 128'(n_re), 128'(exp_beats));
    check("beat_count", 128'(n_fire), 128'(exp_beats));
    check("wreq_accepts", 128'(n_wreq_acc), 128'(exp_active));
    if (!exp_active) check("no_wreq_valid", 128'(n_wreq_cyc), 128'd0);
    check("exp_left", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic run_instr(input logic [5:0] smc, input logic [3:0] bs, input logic [15:0] burst,
                           input logic [63:0] gr, input logic [10:0] ua, input int rm,
                           input logic err, input logic early, input int delay);
    launch(smc, bs, burst, gr, ua, rm, err, early, delay);
    finish_instr();
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_crd"}, 128'(crd_stb_o), 128'd0);
    check({tag, "_ur_re"}, 128'(ur_re), 128'd0);
    check({tag, "_ur_raddr"}, 128'(ur_raddr), 128'd0);
    check({tag, "_wreq_valid"}, 128'(axi_wreq_valid), 128'd0);
    check({tag, "_wreq_addr"}, 128'(axi_wreq_addr), 128'd0);
    check({tag, "_wreq_len"}, 128'(axi_wreq_len), 128'd0);
    check({tag, "_wdata_valid"}, 128'(axi_wdata_valid), 128'd0);
    check({tag, "_wdata"}, axi_wdata, 128'd0);
    check({tag, "_wstrb"}, 128'(axi_wstrb), 128'd0);
    check({tag, "_wlast"}, 128'(axi_wdata_last), 128'd0);
    check({tag, "_state"}, 128'(dbg_state), 128'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [127:0] pat;
    for (int i = 0; i < 2048; i++) ur_mem[i] = rand128();

    // Reset state
    cru_stb_i = rand128();
    repeat (3) @(negedge clk);
    check_outputs_idle("reset");
    check("reset_passthrough", cru_stb_o, cru_stb_i);
    cru_stb_i = '0;
    @(negedge clk);
    rst = 1'b0;

    // Basic burst: 4 full beats, ready held high
    wreq_mode = 0;
    run_instr(6'h01, 4'd0, 16'd4, 64'h100, 11'h010, 0, 1'b0, 1'b0, 2);
    check("basic_wreq_addr_value", 128'(exp_addr), 128'h1000);
    check("basic_latency_le2", 128'((first_valid_cyc - acc_cyc) <= 2), 128'd1);
    check("basic_back_to_back", 128'(last_fire_cyc - first_fire_cyc), 128'd3);

    // Masked single beat with a byte-index pattern
    for (int b = 0; b < 16; b++) pat[b*8 +: 8] = 8'(b);
    ur_mem[11'h020] = pat;
    run_instr(6'h01, 4'd3, 16'd0, 64'h0000_0ABC_0000_1234, 11'h020, 0, 1'b0, 1'b0, 0);

    // Backpressure 1-0-0-1
    run_instr(6'h03, 4'd0, 16'd8, 64'h2000, 11'h100, 1, 1'b0, 1'b0, 1);

    // Error response
    run_instr(6'h01, 4'd5, 16'd2, 64'h3000, 11'h200, 0, 1'b1, 1'b0, 0);

    // SMC not selected: success, no traffic
    run_instr(6'h3E, 4'd0, 16'd4, 64'h4000, 11'h300, 0, 1'b0, 1'b0, 0);

    // Burst too long: error, no traffic
    run_instr(6'h01, 4'd0, 16'd300, 64'h5000, 11'h300, 0, 1'b0, 1'b0, 0);

    // UR address wrap
    run_instr(6'h01, 4'd0, 16'd3, 64'h6000, 11'h7FE, 0, 1'b0, 1'b0, 0);

    // Response arriving before the last beat
    run_instr(6'h01, 4'd9, 16'd6, 64'h7000, 11'h400, 0, 1'b0, 1'b1, 0);

    // Maximum burst length
    run_instr(6'h01, 4'd15, 16'd256, 64'hFFFF_FFFF_FFFF_FFF0, 11'h700, 0, 1'b0, 1'b0, 0);

    // Reset in the middle of DATA, then a normal instruction
    launch(6'h01, 4'd0, 16'd8, 64'h8000, 11'h500, 1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (n_fire >= 2) break;
    end
    check("reset_mid_data_state", 128'(dbg_state), 128'(ST_DATA));
    rst = 1'b1;
    #1;
    check_outputs_idle("midreset");
    clear_expect();
    resp_cd = 0;
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_instr(6'h01, 4'd7, 16'd5, 64'h9000, 11'h600, 0, 1'b0, 1'b0, 0);

    // Randomized instructions with random AXI readiness
    for (int it = 0; it < 10; it++) begin
      logic [5:0] smc;
      smc = 6'($urandom_range(0, 63));
      smc = ($urandom_range(0, 4) == 0) ? (smc & 6'h3E) : (smc | 6'h01);
      wreq_mode = int'($urandom_range(0, 1));
      run_instr(smc, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 20)), {$urandom(), $urandom()},
                11'($urandom_range(0, 2047)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/stb.md
Name: stb

Overview:
- Store-burst engine for the SMC; the write-direction counterpart of the load-burst block.
- On a store instruction from the CRU chain it reads consecutive UR entries, issues one AXI write burst to global memory, and streams the UR data as AXI write beats.
- The final beat is byte-masked.
- It reports completion or error on crd_stb_o and passes the instruction bus through unchanged.

Parameters:
param_ur_byte_cnt  16  UR entry width in bytes (one AXI beat = 16 bytes)
ur_addr_w  11  UR address width
gr_addr_w  64  global byte-address width
brst_w  16  burst-count field width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cru_stb_i  in  128  instruction: [127] vld, [126:121] smc_strb, [120:117] byte_strb, [116:101] burst_cnt, [100:37] gr beat addr, [36:29] ur_id, [28:18] ur_addr
cru_stb_o  out  128  combinational pass-through of cru_stb_i
crd_stb_o  out  2  response {vld, done}
ur_re  out  1  UR read enable
ur_raddr  out  ur_addr_w  UR read address
ur_rdata  in  param_ur_byte_cnt*8  UR read data, valid exactly 1 cycle after ur_re
axi_wreq_valid  out  1  write-burst request valid
axi_wreq_ready  in  1  request accepted
axi_wreq_addr  out  gr_addr_w  burst byte address
axi_wreq_len  out  9  beat count
axi_wdata_valid  out  1  write beat valid
axi_wdata_ready  in  1  write beat accepted
axi_wdata  out  128  beat data
axi_wstrb  out  16  byte strobes
axi_wdata_last  out  1  final beat marker
axi_wresp_done  in  1  burst write response, 1-cycle pulse
axi_wresp_err  in  1  error qualifier, sampled with axi_wresp_done

Behaviour:
- Reset values: all outputs 0 except cru_stb_o; FSM in IDLE; skid buffer empty.
- Reset mid-operation aborts immediately; no response is issued.
- Decoded fields:
  - beats = (burst_cnt==0) ? 1 : burst_cnt.
  - addr = {gr field, 4'b0}, truncated to gr_addr_w.
  - Last-beat mask: byte_strb==0 gives 16'hFFFF; byte_strb==n gives the low n bits set.
- FSM states: IDLE, PARSE, REQ, DATA, RESP, DONE.
- IDLE: cru_stb_i[127]=1 -> PARSE. The instruction must be held stable through PARSE.
- PARSE: latch all fields.
  - smc_strb[0]==0 (SMC not selected) -> DONE as success; no UR or AXI activity.
  - beats>256 -> DONE as error; no AXI activity.
  - Otherwise -> REQ.
- REQ: axi_wreq_valid=1, with addr and len=beats held stable until axi_wreq_ready; on ready -> DATA. UR prefetch may begin in REQ.
- DATA:
  - Issue ur_re with ur_raddr incrementing from the latched ur_addr; UR address wraps modulo 2^ur_addr_w.
  - Returned data enters a 2-entry skid buffer (stb_skid_buf).
  - ur_re is asserted only when the buffer occupancy plus in-flight reads is less than 2. This guarantees no overflow under any axi_wdata_ready pattern.
  - Buffer head drives axi_wdata / axi_wdata_valid; a beat is consumed when valid&&ready.
  - Full beats use wstrb=16'hFFFF. The last beat uses the mask, with unmasked bytes of axi_wdata forced to 0, and asserts axi_wdata_last.
  - Data, strb and last are held stable while valid&&!ready.
  - Last beat accepted -> RESP.
- RESP: wait for axi_wresp_done -> DONE, capturing err = axi_wresp_err.
  - A done pulse arriving before the last beat is accepted is latched and honoured on entry to RESP.
- DONE: crd_stb_o = 2'b11 on success, 2'b10 on error, for exactly one cycle -> IDLE.
- Outside DONE, crd_stb_o = 2'b00.
- A new instruction arriving while not in IDLE is ignored.
- Beat counter width is brst_w; exactly `beats` UR reads and `beats` AXI beats occur per instruction.
- Latency, REQ accept to first axi_wdata_valid: at most 2 cycles (one read-latency cycle plus the buffer register).
- Sustained throughput: 1 beat/cycle when axi_wdata_ready is held high.

Decomposition:
- Shared package smc_pkg holds:
  - instruction field bit-position localparams (shared with the load-burst block);
  - stb_state_t enum;
  - BYTE_PER_BEAT=16;
  - the byte-mask function.
- One sub-module, stb_skid_buf: a 2-entry FIFO of {data[127:0], strb[15:0], last}, with push/pop and count outputs.

Test Plan:
- Basic burst: burst_cnt=4, byte_strb=0, gr=0x100, ur_addr=0x010, ready held 1.
  -> wreq addr=0x1000, len=4; UR reads 0x010..0x013; 4 beats back-to-back, wstrb=FFFF, last on beat 4; done pulse -> crd_stb_o=11 for 1 cycle.
- Masked single beat: burst_cnt=0, byte_strb=3, UR data=0x00..0F pattern.
  -> len=1; wstrb=0007; data bytes 3..15 equal 0; last=1.
- Backpressure: burst_cnt=8, axi_wdata_ready toggled 1-0-0-1 repeatedly.
  -> all 8 beats delivered in order; no UR read outstanding beyond 2; data stable while stalled.
- Error and skip paths:
  - wresp_err=1 with done -> crd=10.
  - smc_strb[0]=0 -> crd=11, with no ur_re and no axi_wreq_valid.
  - burst_cnt=300 -> crd=10 with no AXI activity.
- Wrap and reset: ur_addr=0x7FE, burst_cnt=3 -> reads 0x7FE, 0x7FF, 0x000. Separately, assert rst mid-DATA -> all outputs 0, IDLE, next instruction completes normally.
